// File: rtl/dac_adc_pkg.sv
// Shared types and constants for the DAC/ADC sweep sequencer.
package dac_adc_pkg;

  localparam int unsigned CodeW = 12;
  localparam int unsigned CmdW  = 8;

  localparam logic [3:0]      DAC_CTRL_A  = 4'b0011;
  localparam logic [CmdW-1:0] ADC_CMD_CH0 = 8'b10010111;

  typedef enum logic [3:0] {
    StIdle,
    StDacGo,
    StDacWait,
    StSettle,
    StAdcGo,
    StAdcWait,
    StEmit,
    StNext,
    StFin
  } state_e;

  // Unsigned add clamped to the full-scale DAC code.
  function automatic logic [CodeW-1:0] sat_add(input logic [CodeW-1:0] a,
                                               input logic [CodeW-1:0] b);
    logic [CodeW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CodeW] ? {CodeW{1'b1}} : sum[CodeW-1:0];
  endfunction

endpackage

// File: rtl/dac_adc_sweep_timer.sv
// Settle timer: counts clock cycles while enabled, held at zero otherwise.
module dac_adc_sweep_timer #(
  parameter int unsigned Width = 29
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dac_adc_sweep.sv
// DAC ramp / ADC capture sweep sequencer. Optional macro SWEEP_AVG4_EN averages
// four ADC conversions per point into one result.
module dac_adc_sweep
  import dac_adc_pkg::*;
#(
  parameter int unsigned      SETTLE_W      = 29,
  parameter int unsigned      SETTLE_CYCLES = 39,
  parameter logic [3:0]       DAC_CTRL      = DAC_CTRL_A,
  parameter logic [CmdW-1:0]  ADC_CMD       = ADC_CMD_CH0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CodeW-1:0]     vstart_i,
  input  logic [CodeW-1:0]     vstep_i,
  input  logic [CodeW-1:0]     npts_i,
  output logic                 stdac_o,
  output logic [CodeW+3:0]     din_dac_o,
  input  logic                 eodac_i,
  output logic                 stadc_o,
  output logic [CmdW-1:0]      cmd_adc_o,
  input  logic                 eoadc_i,
  input  logic [CodeW-1:0]     dout_adc_i,
  output logic [CodeW-1:0]     code_o,
  output logic [CodeW-1:0]     data_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [SETTLE_W-1:0] SettleLast = SETTLE_W'(SETTLE_CYCLES);

  state_e               state_q;
  logic [CodeW-1:0]     code_q, step_q, remain_q, adc_q;
  logic [CodeW-1:0]     code_out_q, data_out_q;
  logic [CodeW+3:0]     din_q;
  logic                 stdac_q, stadc_q, valid_q, busy_q, done_q;
  logic [SETTLE_W-1:0]  settle_cnt;

`ifdef SWEEP_AVG4_EN
  logic [1:0]  conv_q;
  logic [13:0] acc_q;
  logic [13:0] acc_sum;
  assign acc_sum = acc_q + {2'b00, dout_adc_i};
`endif

  dac_adc_sweep_timer #(
    .Width (SETTLE_W)
  ) u_settle_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (state_q == StSettle),
    .count_o (settle_cnt)
  );

  // Outputs are registered, so each strobe appears the cycle after its state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      code_q     <= '0;
      step_q     <= '0;
      remain_q   <= '0;
      adc_q      <= '0;
      code_out_q <= '0;
      data_out_q <= '0;
      din_q      <= {DAC_CTRL, {CodeW{1'b0}}};
      stdac_q    <= 1'b0;
      stadc_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SWEEP_AVG4_EN
      conv_q     <= '0;
      acc_q      <= '0;
`endif
    end else begin
      stdac_q <= 1'b0;
      stadc_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            code_q   <= vstart_i;
            step_q   <= vstep_i;
            remain_q <= npts_i;
            busy_q   <= 1'b1;
            state_q  <= (npts_i == '0) ? StFin : StDacGo;
          end
        end
        StDacGo: begin
          stdac_q <= 1'b1;
          din_q   <= {DAC_CTRL, code_q};
          state_q <= StDacWait;
        end
        StDacWait: begin
          if (eodac_i) begin
            state_q <= StSettle;
`ifdef SWEEP_AVG4_EN
            conv_q  <= '0;
            acc_q   <= '0;
`endif
          end
        end
        StSettle: begin
          if (settle_cnt == SettleLast) state_q <= StAdcGo;
        end
        StAdcGo: begin
          stadc_q <= 1'b1;
          state_q <= StAdcWait;
        end
        StAdcWait: begin
          if (eoadc_i) begin
`ifdef SWEEP_AVG4_EN
            acc_q <= acc_sum;
            if (conv_q == 2'd3) begin
              adc_q   <= acc_sum[13:2];
              state_q <= StEmit;
            end else begin
              conv_q  <= conv_q + 2'd1;
              state_q <= StAdcGo;
            end
`else
            adc_q   <= dout_adc_i;
            state_q <= StEmit;
`endif
          end
        end
        StEmit: begin
          valid_q    <= 1'b1;
          code_out_q <= code_q;
          data_out_q <= adc_q;
          state_q    <= StNext;
        end
        StNext: begin
          remain_q <= remain_q - 1'b1;
          if (remain_q == 12'd1) begin
            state_q <= StFin;
          end else begin
            code_q  <= sat_add(code_q, step_q);
            state_q <= StDacGo;
          end
        end
        StFin: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stdac_o   = stdac_q;
  assign din_dac_o = din_q;
  assign stadc_o   = stadc_q;
  assign cmd_adc_o = ADC_CMD;
  assign code_o    = code_out_q;
  assign data_o    = data_out_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_dac_adc_sweep.sv
// Scoreboard bench for dac_adc_sweep with behavioural DAC/ADC sub-block models.
module tb_dac_adc_sweep;

  localparam int TDAC   = 16;
  localparam int TADC   = 40;
  localparam int SETTLE = 39;
`ifdef SWEEP_AVG4_EN
  localparam int CONV = 4;
`else
  localparam int CONV = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_i, start_i;
  logic [11:0] vstart_i, vstep_i, npts_i;
  logic        stdac_o, stadc_o, valid_o, busy_o, done_o;
  logic [15:0] din_dac_o;
  logic [7:0]  cmd_adc_o;
  logic [11:0] code_o, data_o, dout_adc_i;
  logic        eodac_i = 1'b0;
  logic        eoadc_i;
  logic        eoadc_m = 1'b0, spur = 1'b0;
  logic [11:0] dout_m = '0;

  assign eoadc_i    = eoadc_m | spur;
  assign dout_adc_i = spur ? 12'hABC : dout_m;

  dac_adc_sweep dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .vstart_i   (vstart_i),
    .vstep_i    (vstep_i),
    .npts_i     (npts_i),
    .stdac_o    (stdac_o),
    .din_dac_o  (din_dac_o),
    .eodac_i    (eodac_i),
    .stadc_o    (stadc_o),
    .cmd_adc_o  (cmd_adc_o),
    .eoadc_i    (eoadc_i),
    .dout_adc_i (dout_adc_i),
    .code_o     (code_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0, n_pass = 0;
  logic [15:0] exp_din[$];
  logic [23:0] exp_res[$];
  logic [11:0] adc_vals[$];
  int n_stdac = 0, n_stadc = 0, n_valid = 0, n_done = 0;
  int last_eodac = 0;
  bit armed = 1'b0;
  int start_cyc = 0, ev_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Pulse counters and the DAC-settle gap check
  always @(negedge clk) begin
    if (stdac_o === 1'b1) n_stdac++;
    if (stadc_o === 1'b1) n_stadc++;
    if (done_o === 1'b1) n_done++;
    if (eodac_i) begin
      last_eodac = cyc;
      armed = 1'b1;
    end
    if (stadc_o === 1'b1 && armed) begin
      chk("settle_gap_ge_40", (cyc - last_eodac >= SETTLE + 1) ? 1 : 0, 1);
      armed = 1'b0;
    end
  end

  // Scoreboard monitor
  logic [23:0] mon_e;
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      n_valid++;
      if (exp_res.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        mon_e = exp_res.pop_front();
        chk("code_o", code_o, mon_e[23:12]);
        chk("data_o", data_o, mon_e[11:0]);
      end
    end
  end

  // DAC writer model
  logic [15:0] dac_d;
  bit dac_stable;
  initial begin
    forever begin
      @(negedge clk);
      if (stdac_o === 1'b1) begin
        if (exp_din.size() == 0) chk("unexpected_stdac", 1, 0);
        else chk("din_dac_o", din_dac_o, exp_din.pop_front());
        dac_d = din_dac_o;
        dac_stable = 1'b1;
        for (int i = 0; i < TDAC - 1; i++) begin
          @(negedge clk);
          if (din_dac_o !== dac_d) dac_stable = 1'b0;
        end
        @(posedge clk);
        #1 eodac_i = 1'b1;
        @(posedge clk);
        #1 eodac_i = 1'b0;
        chk("din_dac_stable", dac_stable, 1);
      end
    end
  end

  // ADC reader model
  logic [11:0] adc_v;
  initial begin
    forever begin
      @(negedge clk);
      if (stadc_o === 1'b1) begin
        if (adc_vals.size() == 0) begin
          chk("unexpected_stadc", 1, 0);
          adc_v = '0;
        end else begin
          adc_v = adc_vals.pop_front();
        end
        for (int i = 0; i < TADC - 1; i++) @(negedge clk);
        @(posedge clk);
        #1 begin dout_m = adc_v; eoadc_m = 1'b1; end
        @(posedge clk);
        #1 eoadc_m = 1'b0;
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    chk({name, "_strobes"}, {27'd0, stdac_o, stadc_o, valid_o, busy_o, done_o}, 0);
    chk({name, "_code_data"}, {8'd0, code_o, data_o}, 0);
    chk({name, "_din"}, din_dac_o, 16'h3000);
    chk({name, "_cmd"}, cmd_adc_o, 8'h97);
  endtask

  // Reference model: expected codes/results for a whole sweep
  task automatic launch(input logic [11:0] vs, input logic [11:0] st, input logic [11:0] np,
                        input bit fixed_avg);
    int code, sum;
    logic [11:0] v;
    for (int i = 0; i < int'(np); i++) begin
      code = int'(vs) + i * int'(st);
      if (code > 4095) code = 4095;
      exp_din.push_back({4'h3, code[11:0]});
      sum = 0;
      for (int k = 0; k < CONV; k++) begin
        v = fixed_avg ? 12'(100 + k) : 12'($urandom_range(0, 4095));
        adc_vals.push_back(v);
        sum += int'(v);
      end
      sum = sum / CONV;
      exp_res.push_back({code[11:0], sum[11:0]});
    end
    @(posedge clk);
    #1;
    start_i = 1'b1; vstart_i = vs; vstep_i = st; npts_i = np;
    start_cyc = cyc;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_ev(input int sel, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sel == 0) hit = eodac_i;
      else if (sel == 1) hit = (stadc_o === 1'b1);
      else hit = (done_o === 1'b1);
      if (hit) begin
        ev_cyc = cyc;
        break;
      end
    end
    if (!hit) chk("wait_timeout", 0, 1);
  endtask

  task automatic finish_sweep(input int np, input int s_dac, input int s_adc, input int s_val);
    wait_ev(2, 30000);
    chk("busy_at_done", busy_o, 0);
    chk("results_drained", exp_res.size(), 0);
    chk("valid_count", n_valid - s_val, np);
    chk("stdac_count", n_stdac - s_dac, np);
    chk("stadc_count", n_stadc - s_adc, np * CONV);
    repeat (3) @(posedge clk);
  endtask

  int s_dac, s_adc, s_val, s_done;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; vstart_i = '0; vstep_i = '0; npts_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst_i = 1'b0;

    // Directed ramp
    s_dac = n_stdac; s_adc = n_stadc; s_val = n_valid;
    launch(12'h100, 12'h010, 12'd3, 1'b0);
    @(negedge clk);
    chk("busy_during_sweep", busy_o, 1);
    finish_sweep(3, s_dac, s_adc, s_val);

    // Zero-point sweep
    s_dac = n_stdac; s_adc = n_stadc; s_val = n_valid;
    launch(12'h123, 12'h001, 12'd0, 1'b0);
    finish_sweep(0, s_dac, s_adc, s_val);
    chk("npts0_done_latency", ev_cyc - start_cyc, 2);

    // Saturation
    s_dac = n_stdac; s_adc = n_stadc; s_val = n_valid;
    launch(12'hFF0, 12'h020, 12'd3, 1'b0);
    finish_sweep(3, s_dac, s_adc, s_val);

    // Spurious eoadc in SETTLE and start during ADC_WAIT
    s_dac = n_stdac; s_adc = n_stadc; s_val = n_valid;
    launch(12'h200, 12'h033, 12'd2, 1'b0);
    wait_ev(0, 5000);
    repeat (5) @(posedge clk);
    #1 spur = 1'b1;
    @(posedge clk);
    #1 spur = 1'b0;
    wait_ev(1, 5000);
    repeat (3) @(posedge clk);
    #1 begin start_i = 1'b1; vstart_i = 12'h007; npts_i = 12'd5; end
    @(posedge clk);
    #1 start_i = 1'b0;
    finish_sweep(2, s_dac, s_adc, s_val);

    // Reset during SETTLE of point 2
    launch(12'h050, 12'h100, 12'd3, 1'b0);
    wait_ev(0, 5000);
    wait_ev(0, 5000);
    repeat (10) @(posedge clk);
    #1 rst_i = 1'b1;
    s_done = n_done;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (200) @(negedge clk);
    chk("no_done_after_reset", n_done - s_done, 0);
    exp_res.delete();
    exp_din.delete();
    adc_vals.delete();
    s_dac = n_stdac; s_adc = n_stadc; s_val = n_valid;
    launch(12'h400, 12'h004, 12'd2, 1'b0);
    finish_sweep(2, s_dac, s_adc, s_val);

`ifdef SWEEP_AVG4_EN
    // Averaging of 100..103 gives 101
    s_dac = n_stdac; s_adc = n_stadc; s_val = n_valid;
    launch(12'h300, 12'h001, 12'd2, 1'b1);
    finish_sweep(2, s_dac, s_adc, s_val);
`endif

    // Randomized sweeps
    for (int r = 0; r < 4; r++) begin
      s_dac = n_stdac; s_adc = n_stadc; s_val = n_valid;
      launch(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 2047)),
             12'($urandom_range(1, 4)), 1'b0);
      finish_sweep(int'(npts_i), s_dac, s_adc, s_val);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
